wb_ctrl: RTL

//   Writeback controller that produces the register-file write port (wr_en, rd_addr, rd_data).
//   It merges two result sources:
//     - the single-cycle ALU/execute path, which has priority and no backpressure;
//     - the multi-cycle memory/load path, which uses a valid/ready handshake.

---
 rtl/wb_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_ctrl.sv
// Writeback controller: merges ALU and memory results onto the register-file
// write port, queueing losing memory results in a small squashable FIFO.
module wb_ctrl #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [AW-1:0]     ex_rd_addr_i,
  input  logic [XLEN-1:0]   ex_rd_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [AW-1:0]     mem_rd_addr_i,
  input  logic [XLEN-1:0]   mem_rd_data_i,
  output logic              wr_en,
  output logic [AW-1:0]     rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [2**AW-1:0]  pending_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2**AW;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]   addr_q [DEPTH];
  logic [AW-1:0]   addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];

  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [NR-1:0]   pend_q, pend_d;

  logic fifo_empty;
  logic mem_fire;
  logic sel_pop;
  logic sel_mem;
  logic push;
  logic pop;
  logic same_rd;

  // No fall-through: readiness looks only at the registered count.
  assign mem_ready_o = !rst && (cnt_q < CW'(DEPTH));

  always_comb begin
    fifo_empty = (cnt_q == '0);
    mem_fire   = mem_valid_i && mem_ready_o;
    sel_pop    = !ex_valid_i && !fifo_empty;
    sel_mem    = !ex_valid_i && fifo_empty && mem_fire;
    push       = mem_fire && !sel_mem &&
                 (mem_rd_addr_i != '0);
    pop        = sel_pop;
    same_rd    = ex_valid_i &&
                 (mem_rd_addr_i == ex_rd_addr_i);
  end

  always_comb begin
    vld_d    = vld_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    // A younger ALU write kills queued writes to the same register.
    for (int i = 0; i < DEPTH; i++) begin
      if (ex_valid_i && addr_q[i] == ex_rd_addr_i) begin
        vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q]  = !same_rd;
      addr_d[wr_ptr_q] = mem_rd_addr_i;
      data_d[wr_ptr_q] = mem_rd_data_i;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    wr_en_d = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (1'b1)
      ex_valid_i: begin
        wr_en_d = (ex_rd_addr_i != '0);
        wa_d    = ex_rd_addr_i;
        wd_d    = ex_rd_data_i;
      end
      sel_pop: begin
        wr_en_d = vld_q[rd_ptr_q];
        wa_d    = addr_q[rd_ptr_q];
        wd_d    = data_q[rd_ptr_q];
      end
      sel_mem: begin
        wr_en_d = (mem_rd_addr_i != '0);
        wa_d    = mem_rd_addr_i;
        wd_d    = mem_rd_data_i;
      end
      default: wr_en_d = 1'b0;
    endcase
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_d[i]) begin
        pend_d[addr_d[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      wr_en_q  <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      pend_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      wr_en_q  <= wr_en_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      pend_q   <= pend_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign rd_addr_o = wa_q;
  assign rd_data_o = wd_q;
  assign pending_o = pend_q;

endmodule
